// File: rtl/spi_adc_emu_pkg.sv
// Shared constants, state encoding and command-field helper for the SPI ADC emulator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_adc_emu_pkg;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 2;
  localparam int SAMPLE_W   = 16;
  localparam int CMD_W      = 8;
  localparam int FRAME_BITS = CMD_W + SAMPLE_W;   // 24 SCK rising edges per good frame
  localparam int START_BIT  = 7;
  localparam int CH_LSB     = 5;
  localparam int CNT_W      = 5;                  // holds 0..FRAME_BITS

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    OVERRUN = 2'd3
  } state_t;

  // Channel field of a fully received command byte.
  function automatic logic [CH_W-1:0] cmd_channel(input logic [CMD_W-1:0] cmd);
    return cmd[CH_LSB +: CH_W];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus an edge-detect flop.
// Latency: level is 2 cycles behind the pin; rise/fall pulses are high in the 3rd cycle.
// Backpressure: none; every input edge produces exactly one pulse.
module spi_pin_sync (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  // Resetting to 0 means a chip select already low when reset releases never
  // looks like a falling edge, so a frame interrupted by reset is ignored to its end.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      prev <= sync[1];
    end
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~prev;
  assign fall  = ~sync[1] & prev;

endmodule

// File: rtl/spi_adc_emulator.sv
// SPI mode-0 slave emulating a 4-channel ADC: 8-bit command in, 16-bit preloaded sample out.
// Latency: pin edges acted on 3 cycles after arrival; MISO/OE/frame status registered (<=4 cycles).
// Backpressure: none; the master owns SCK, sample loads are accepted every cycle.
module spi_adc_emulator
  import spi_adc_emu_pkg::*;
(
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic                spi_sck,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  input  logic                sample_wr,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                frame_done,
  output logic [CH_W-1:0]     frame_ch,
  output logic                frame_err,
  output logic [15:0]         frame_count
);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_BITS);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync u_sync_sck (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .pin        (spi_sck),
    .level      (sck_level_unused),
    .rise       (sck_rise),
    .fall       (sck_fall)
  );

  spi_pin_sync u_sync_cs (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .pin        (spi_cs_n),
    .level      (cs_level_unused),
    .rise       (cs_rise),
    .fall       (cs_fall)
  );

  spi_pin_sync u_sync_mosi (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .pin        (spi_mosi),
    .level      (mosi_level),
    .rise       (mosi_rise_unused),
    .fall       (mosi_fall_unused)
  );

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CMD_W-1:0]      cmd_sr;
  logic [CMD_W-1:0]      cmd_next;
  logic [SAMPLE_W-1:0]   data_sr;
  logic [CH_W-1:0]       cur_ch;
  logic [SAMPLE_W-1:0]   ch_reg [NUM_CH];

  assign cmd_next = {cmd_sr[CMD_W-2:0], mosi_level};

  // Channel register file; a write landing on the snapshot cycle is seen by the next frame only.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_reg[i] <= '0;
    end else if (sample_wr) begin
      ch_reg[sample_ch] <= sample_data;
    end
  end

  // Frame FSM: CS_N edges take priority over any SCK edge detected in the same cycle.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      data_sr     <= '0;
      cur_ch      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_ch    <= '0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_rise) begin
        if (state != IDLE) begin
          if (state == DATA && bit_cnt == CNT_FULL) begin
            frame_done  <= 1'b1;
            frame_ch    <= cur_ch;
            frame_count <= frame_count + 16'd1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (cs_fall) begin
        state       <= CMD;
        bit_cnt     <= '0;
        cmd_sr      <= '0;
        data_sr     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b1;
      end else if (sck_rise) begin
        case (state)
          CMD: begin
            cmd_sr  <= cmd_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_CMD_LAST) begin
              if (cmd_next[START_BIT]) begin
                state   <= DATA;
                data_sr <= ch_reg[cmd_channel(cmd_next)];
                cur_ch  <= cmd_channel(cmd_next);
              end else begin
                state <= OVERRUN;
              end
            end
          end
          DATA: begin
            if (bit_cnt == CNT_FULL) state <= OVERRUN;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end else if (sck_fall) begin
        // Zero-filled shift makes MISO fall back to 0 once all 16 data bits are out.
        if (state == DATA) begin
          spi_miso <= data_sr[SAMPLE_W-1];
          data_sr  <= {data_sr[SAMPLE_W-2:0], 1'b0};
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_emulator.sv
// Self-checking bench for spi_adc_emulator: directed scenarios plus randomized frames.
// Latency: master timing is clock-aligned, 10 MHz SCK (5 clk_100mhz cycles per half period).
// Backpressure: not applicable.
module tb_spi_adc_emulator;

  logic        clk_100mhz;
  logic        rst_n;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        sample_wr;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        frame_done, frame_err;
  logic [1:0]  frame_ch;
  logic [15:0] frame_count;

  spi_adc_emulator dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .sample_wr   (sample_wr),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .frame_done  (frame_done),
    .frame_ch    (frame_ch),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] model_reg [4];
  logic [15:0] model_count;
  logic [1:0]  model_ch;

  // Pulse monitors: count every cycle each status line is high.
  int done_cyc = 0;
  int err_cyc  = 0;
  always @(negedge clk_100mhz) begin
    if (frame_done === 1'b1) done_cyc++;
    if (frame_err === 1'b1) err_cyc++;
  end

  // Results of the last frame
  logic [31:0] rx, oev;
  logic        miso_after, oe_after;
  int          d_delta, e_delta;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic load(input logic [1:0] ch, input logic [15:0] val);
    sample_wr = 1'b1; sample_ch = ch; sample_data = val;
    wait_cyc(1);
    sample_wr = 1'b0;
    model_reg[ch] = val;
  endtask

  // Expected MISO seen by the master just before each rising edge (index n = just before CS_N rise).
  function automatic logic [31:0] exp_rx(input logic [7:0] cmd, input logic [15:0] d,
                                         input int n, input int rst_at);
    logic [31:0] r = '0;
    for (int i = 0; i <= n; i++)
      if ((rst_at < 0 || i <= rst_at) && cmd[7] && i >= 8 && i < 24) r[i] = d[23 - i];
    return r;
  endfunction

  function automatic logic [31:0] exp_oe(input int n, input int rst_at);
    logic [31:0] r = '0;
    for (int i = 0; i <= n; i++) r[i] = !(rst_at >= 0 && i > rst_at);
    return r;
  endfunction

  // Master: CS_N fall, n SCK pulses, optional reset or snapshot-cycle write during edge high phases.
  task automatic run_frame(input logic [7:0] cmd, input int n, input int rst_at,
                           input logic do_snap, input logic [15:0] snap_val);
    logic [7:0] c;
    int d0, e0;
    d0 = done_cyc; e0 = err_cyc;
    rx = '0; oev = '0;
    c = cmd;
    spi_cs_n = 1'b0;
    spi_mosi = c[7];
    c = c << 1;
    wait_cyc(5);
    for (int i = 0; i < n; i++) begin
      rx[i] = spi_miso; oev[i] = spi_miso_oe;
      spi_sck = 1'b1;
      if (do_snap && i == 7) begin
        wait_cyc(2);
        sample_wr = 1'b1; sample_ch = cmd[6:5]; sample_data = snap_val;
        wait_cyc(1);
        sample_wr = 1'b0;
        wait_cyc(2);
      end else if (i == rst_at) begin
        wait_cyc(1);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
      end else begin
        wait_cyc(5);
      end
      spi_sck = 1'b0;
      spi_mosi = (i < 7) ? c[7] : 1'($urandom_range(0, 1));
      c = c << 1;
      wait_cyc(5);
    end
    rx[n] = spi_miso; oev[n] = spi_miso_oe;
    spi_cs_n = 1'b1;
    wait_cyc(8);
    miso_after = spi_miso; oe_after = spi_miso_oe;
    d_delta = done_cyc - d0; e_delta = err_cyc - e0;
  endtask

  // Model update for a frame with no reset inside it.
  task automatic model_frame(input logic [7:0] cmd, input int n, output logic good);
    good = cmd[7] && (n == 24);
    if (good) begin
      model_count = model_count + 16'd1;
      model_ch = cmd[6:5];
    end
  endtask

  task automatic test_reset;
    if (spi_miso !== 1'b0) begin $display("FAIL reset_miso: got %b expected 0", spi_miso); miscompares++; end
    vectors++;
    if (spi_miso_oe !== 1'b0) begin $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); miscompares++; end
    vectors++;
    if (frame_count !== 16'd0 || frame_ch !== 2'd0) begin
      $display("FAIL reset_status: count %h ch %0d expected 0 0", frame_count, frame_ch); miscompares++;
    end
    vectors++;
    if (done_cyc !== 0 || err_cyc !== 0) begin
      $display("FAIL reset_pulses: done %0d err %0d expected 0 0", done_cyc, err_cyc); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_basic;
    logic g;
    load(2'd2, 16'hA5C3);
    run_frame(8'hC0, 24, -1, 1'b0, 16'h0);
    model_frame(8'hC0, 24, g);
    if (rx !== exp_rx(8'hC0, 16'hA5C3, 24, -1)) begin
      $display("FAIL basic_rx: got %h expected %h", rx, exp_rx(8'hC0, 16'hA5C3, 24, -1)); miscompares++;
    end
    vectors++;
    if (oev !== exp_oe(24, -1) || oe_after !== 1'b0 || miso_after !== 1'b0) begin
      $display("FAIL basic_oe: oe %h after %b miso_after %b expected %h 0 0", oev, oe_after, miso_after, exp_oe(24, -1));
      miscompares++;
    end
    vectors++;
    if (d_delta !== 1 || e_delta !== 0) begin
      $display("FAIL basic_pulse: done %0d err %0d expected 1 0", d_delta, e_delta); miscompares++;
    end
    vectors++;
    if (frame_ch !== model_ch || frame_count !== model_count) begin
      $display("FAIL basic_status: ch %0d count %0d expected %0d %0d", frame_ch, frame_count, model_ch, model_count);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_bad_start;
    logic g;
    run_frame(8'h40, 24, -1, 1'b0, 16'h0);
    model_frame(8'h40, 24, g);
    if (rx !== 32'h0) begin $display("FAIL badstart_rx: got %h expected 0", rx); miscompares++; end
    vectors++;
    if (d_delta !== 0 || e_delta !== 1) begin
      $display("FAIL badstart_pulse: done %0d err %0d expected 0 1", d_delta, e_delta); miscompares++;
    end
    vectors++;
    if (frame_count !== model_count) begin
      $display("FAIL badstart_count: got %0d expected %0d", frame_count, model_count); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_short;
    logic g;
    run_frame(8'hC0, 12, -1, 1'b0, 16'h0);
    model_frame(8'hC0, 12, g);
    if (rx !== exp_rx(8'hC0, model_reg[2], 12, -1) || miso_after !== 1'b0) begin
      $display("FAIL short_rx: got %h after %b expected %h 0", rx, miso_after, exp_rx(8'hC0, model_reg[2], 12, -1));
      miscompares++;
    end
    vectors++;
    if (d_delta !== 0 || e_delta !== 1) begin
      $display("FAIL short_pulse: done %0d err %0d expected 0 1", d_delta, e_delta); miscompares++;
    end
    vectors++;
    load(2'd0, 16'h1234);
    run_frame(8'h80, 24, -1, 1'b0, 16'h0);
    model_frame(8'h80, 24, g);
    if (rx !== exp_rx(8'h80, 16'h1234, 24, -1) || d_delta !== 1) begin
      $display("FAIL short_next: rx %h done %0d expected %h 1", rx, d_delta, exp_rx(8'h80, 16'h1234, 24, -1));
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_overrun;
    logic g;
    run_frame(8'hC0, 26, -1, 1'b0, 16'h0);
    model_frame(8'hC0, 26, g);
    if (rx !== exp_rx(8'hC0, model_reg[2], 26, -1)) begin
      $display("FAIL overrun_rx: got %h expected %h", rx, exp_rx(8'hC0, model_reg[2], 26, -1)); miscompares++;
    end
    vectors++;
    if (d_delta !== 0 || e_delta !== 1 || frame_count !== model_count) begin
      $display("FAIL overrun_pulse: done %0d err %0d count %0d expected 0 1 %0d", d_delta, e_delta, frame_count, model_count);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_snapshot;
    logic g;
    load(2'd1, 16'h0001);
    run_frame(8'hA0, 24, -1, 1'b1, 16'hFFFF);
    model_frame(8'hA0, 24, g);
    if (rx !== exp_rx(8'hA0, 16'h0001, 24, -1) || d_delta !== 1) begin
      $display("FAIL snap_old: rx %h done %0d expected %h 1", rx, d_delta, exp_rx(8'hA0, 16'h0001, 24, -1));
      miscompares++;
    end
    vectors++;
    model_reg[1] = 16'hFFFF;
    run_frame(8'hA0, 24, -1, 1'b0, 16'h0);
    model_frame(8'hA0, 24, g);
    if (rx !== exp_rx(8'hA0, 16'hFFFF, 24, -1) || frame_ch !== 2'd1) begin
      $display("FAIL snap_new: rx %h ch %0d expected %h 1", rx, frame_ch, exp_rx(8'hA0, 16'hFFFF, 24, -1));
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_mid;
    logic g;
    load(2'd3, 16'hBEEF);
    run_frame(8'hE0, 24, 14, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) model_reg[i] = 16'h0;
    model_count = 16'h0; model_ch = 2'd0;
    if (rx !== exp_rx(8'hE0, 16'hBEEF, 24, 14) || oev !== exp_oe(24, 14)) begin
      $display("FAIL rstmid_pins: rx %h oe %h expected %h %h", rx, oev, exp_rx(8'hE0, 16'hBEEF, 24, 14), exp_oe(24, 14));
      miscompares++;
    end
    vectors++;
    if (d_delta !== 0 || e_delta !== 0 || frame_count !== 16'd0 || frame_ch !== 2'd0) begin
      $display("FAIL rstmid_status: done %0d err %0d count %0d ch %0d expected 0 0 0 0", d_delta, e_delta, frame_count, frame_ch);
      miscompares++;
    end
    vectors++;
    run_frame(8'hE0, 24, -1, 1'b0, 16'h0);
    model_frame(8'hE0, 24, g);
    if (rx !== 32'h0 || d_delta !== 1 || frame_count !== model_count || frame_ch !== 2'd3) begin
      $display("FAIL rstmid_next: rx %h done %0d count %0d ch %0d expected 0 1 %0d 3", rx, d_delta, frame_count, frame_ch, model_count);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random;
    logic [7:0]  cmd;
    logic [15:0] d;
    int          n;
    logic        g;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) load(2'($urandom_range(0, 3)), 16'($urandom));
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cmd[7] = 1'b1;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 26)) : 24;
      d = model_reg[cmd[6:5]];
      run_frame(cmd, n, -1, 1'b0, 16'h0);
      model_frame(cmd, n, g);
      if (rx !== exp_rx(cmd, d, n, -1)) begin
        $display("FAIL rand_rx[%0d]: cmd %h n %0d got %h expected %h", k, cmd, n, rx, exp_rx(cmd, d, n, -1));
        miscompares++;
      end
      vectors++;
      if (d_delta !== int'(g) || e_delta !== int'(!g)) begin
        $display("FAIL rand_pulse[%0d]: done %0d err %0d expected %0d %0d", k, d_delta, e_delta, g, !g);
        miscompares++;
      end
      vectors++;
      if (frame_count !== model_count || frame_ch !== model_ch) begin
        $display("FAIL rand_status[%0d]: count %0d ch %0d expected %0d %0d", k, frame_count, frame_ch, model_count, model_ch);
        miscompares++;
      end
      vectors++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    sample_wr = 1'b0; sample_ch = 2'd0; sample_data = 16'h0;
    for (int i = 0; i < 4; i++) model_reg[i] = 16'h0;
    model_count = 16'h0; model_ch = 2'd0;
    repeat (3) @(posedge clk_100mhz);
    #1 rst_n = 1'b1;
    wait_cyc(8);
    test_reset;
    test_basic;
    test_bad_start;
    test_short;
    test_overrun;
    test_snapshot;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_adc_emulator.md
# spi_adc_emulator

SPI mode-0 slave that answers the inverter controller's ADC SPI master (SCK/MOSI/MISO/CS_N) exactly as the external 4-channel ADC does. It is used for hardware-in-the-loop bring-up on a second Basys 3 or in loopback. Samples are preloaded per channel through a simple load port, and the block reports frame completion, channel and protocol errors. It runs entirely in the clk_100mhz domain and oversamples the SPI pins.

## Interface
- NUM_CH, 4, number of emulated channels (channel field width CH_W = 2)
- SAMPLE_W, 16, data bits returned per frame, MSB first
- CMD_W, 8, command bits received per frame

Ports (reset rst_n, asynchronous, active-low; clock clk_100mhz):
- clk_100mhz  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- spi_sck  in  1  SPI clock from master, asynchronous, idle low
- spi_cs_n  in  1  chip select from master, asynchronous, active low
- spi_mosi  in  1  command data from master
- spi_miso  out  1  sample data to master
- spi_miso_oe  out  1  1 while synchronized CS_N is low (pad tristate enable)
- sample_wr  in  1  load strobe, one cycle
- sample_ch  in  CH_W  channel to load
- sample_data  in  SAMPLE_W  value to load
- frame_done  out  1  one-cycle pulse at end of a good frame
- frame_ch  out  CH_W  channel of the last good frame
- frame_err  out  1  one-cycle pulse at end of a bad frame
- frame_count  out  16  good-frame counter, wraps 0xFFFF→0

## Operation
- Frame: CS_N falls, master gives CMD_W+SAMPLE_W = 24 SCK rising edges, then CS_N rises.
- Command: MSB first. cmd[7] is the start bit and must be 1. cmd[6:5] selects the channel. cmd[4:0] is ignored.
- MOSI is sampled on each synchronized SCK rising edge. MISO changes only on synchronized SCK falling edges, or on CS_N falling.
- MISO is 0 from CS_N fall through the 8th falling edge.
- On the 8th rising edge, if the start bit is 1, the selected channel register is copied into the shift register (snapshot).
- At the 8th falling edge MISO drives the data MSB. Each later falling edge shifts in the next bit. After the 16th data bit is sent, MISO returns to 0.
- States: IDLE, CMD, DATA, OVERRUN.
  - IDLE→CMD on CS_N falling edge. The bit counter clears to 0.
  - CMD→DATA on the 8th rising edge when the start bit is 1.
  - CMD→OVERRUN on the 8th rising edge when the start bit is 0. MISO stays 0 for the rest of the frame.
  - DATA→OVERRUN on a 25th rising edge.
  - Any state→IDLE on CS_N rising edge.
- End of frame on CS_N rising edge:
  - Good frame: state DATA with exactly 24 rising edges. Pulse frame_done, update frame_ch, increment frame_count.
  - Anything else (abort mid-frame, short frame, overrun, bad start bit): pulse frame_err only.
- CS_N rising in IDLE produces nothing.
- Channel registers: NUM_CH × SAMPLE_W, reset to 0. sample_wr writes sample_data into reg[sample_ch] at the next clock edge.
- Simultaneous sample_wr to the snapshot channel in the snapshot cycle: the snapshot takes the old value. The new value is visible to the next frame.
- Writes during a frame never alter the in-flight shift register.
- SCK edges while CS_N is high are ignored.
- Reset asserted mid-frame: everything clears to IDLE. The remainder of that frame is ignored, because a fresh CS_N falling edge is required.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, frame_done 0, frame_err 0, frame_ch 0, frame_count 0, state IDLE, bit counter 0, channel registers 0.
- Pin synchronizers: 2 flops per pin, then 1 edge-detect flop. An SPI pin edge is acted on 3 clk_100mhz cycles after it arrives.
- spi_miso is registered and valid ≤4 cycles (40 ns) after an SCK falling edge or CS_N falling edge.
- spi_miso_oe follows synchronized CS_N with the same 4-cycle latency.
- Supported range:
  - f_SCK ≤ 10 MHz, with SCK high and low each ≥ 50 ns.
  - CS_N setup to the first SCK rise ≥ 50 ns.
  - CS_N high time ≥ 50 ns.
- frame_done / frame_err assert 3 cycles after the CS_N rising edge, for exactly 1 cycle. frame_ch and frame_count update in the same cycle as frame_done.
- A CS_N rising edge and an SCK edge detected in the same cycle: CS_N wins, and the SCK edge is discarded.

## Structure
- Package spi_adc_emu_pkg holds:
  - the state enum (IDLE, CMD, DATA, OVERRUN);
  - CMD_W, SAMPLE_W, FRAME_BITS = 24, START_BIT = 7, CH_LSB = 5, CH_W = 2.
- Sub-module spi_pin_sync: 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated three times, for sck, cs_n and mosi (mosi uses the level output only).
- Top holds the FSM, bit counter, command shift register, data shift register, channel register file and status counters.

## Test plan
- Load ch2=0xA5C3, then a frame at 10 MHz with cmd 0xC0: MISO reads 0x00 during the command and 0xA5C3 during data. frame_done pulses once, frame_ch=2, frame_count=1.
- cmd 0x40 (start bit 0): MISO is all 0 for all 24 bits, and frame_err pulses. frame_count does not change.
- CS_N rises after 12 SCK edges: frame_err pulses and MISO returns to 0. The next full frame reading ch0 (loaded 0x1234) returns 0x1234.
- 26 SCK edges: the first 16 data bits are correct, the extras are 0, and frame_err pulses.
- sample_wr ch1=0xFFFF in the snapshot cycle of a ch1 read (old value 0x0001): the frame returns 0x0001, and the following frame returns 0xFFFF.
- Reset pulsed at bit 15 of a frame, with CS_N held low: no frame_done or frame_err. Outputs stay at reset values until the next CS_N fall, and that frame reads 0x0000.
